voxel_dda_stepper: RTL and testbench

- 3D-DDA voxel traversal engine for a 32x32x32 grid. Accepts one ray setup (start voxel, per-axis step direction, initial tMax, tDelta) and emits the ordered sequence of voxel coordinates the ray crosses, one per accepted beat.
- Sits directly upstream of voxel_addr_map: out_x/out_y/out_z drive its x/y/z inputs, and the resulting address feeds voxel memory lookup.
- Traversal ends when the ray leaves the grid or the step budget is exhausted.

---
 rtl/voxel_dda_stepper.sv | 164 ++++++++++++++++
 tb/tb_voxel_dda_stepper.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/voxel_dda_stepper.sv
// 3D-DDA voxel traversal engine: walks a ray through a 32x32x32 grid, one voxel per accepted beat.
// Optional DDA_STEP_CNT_EN adds the out_step beat-index output.
module voxel_dda_stepper #(
  parameter int X_BITS    = 5,
  parameter int Y_BITS    = 5,
  parameter int Z_BITS    = 5,
  parameter int T_BITS    = 16,
  parameter int STEP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [X_BITS-1:0]    start_x,
  input  logic [Y_BITS-1:0]    start_y,
  input  logic [Z_BITS-1:0]    start_z,
  input  logic [1:0]           dir_x,
  input  logic [1:0]           dir_y,
  input  logic [1:0]           dir_z,
  input  logic [T_BITS-1:0]    tmax_x,
  input  logic [T_BITS-1:0]    tmax_y,
  input  logic [T_BITS-1:0]    tmax_z,
  input  logic [T_BITS-1:0]    tdelta_x,
  input  logic [T_BITS-1:0]    tdelta_y,
  input  logic [T_BITS-1:0]    tdelta_z,
  input  logic [STEP_BITS-1:0] max_steps,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [X_BITS-1:0]    out_x,
  output logic [Y_BITS-1:0]    out_y,
  output logic [Z_BITS-1:0]    out_z,
  output logic                 out_last,
`ifdef DDA_STEP_CNT_EN
  output logic                 busy,
  output logic [STEP_BITS-1:0] out_step
`else
  output logic                 busy
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_state, w_next_state;

  logic [X_BITS-1:0]    r_x;
  logic [Y_BITS-1:0]    r_y;
  logic [Z_BITS-1:0]    r_z;
  logic [1:0]           r_dir_x, r_dir_y, r_dir_z;
  logic [T_BITS-1:0]    r_tmax_x, r_tmax_y, r_tmax_z;
  logic [T_BITS-1:0]    r_tdelta_x, r_tdelta_y, r_tdelta_z;
  logic [STEP_BITS-1:0] r_eff_max;
  logic [STEP_BITS-1:0] r_cnt;

  logic w_act_x, w_act_y, w_act_z;
  logic w_sel_x, w_sel_y, w_sel_z;
  logic w_exit, w_budget_done, w_accept, w_beat;

  // Direction encoding: bit0 = axis moves, bit1 = negative when moving.
  assign w_act_x = r_dir_x[0];
  assign w_act_y = r_dir_y[0];
  assign w_act_z = r_dir_z[0];

  // Smallest tMax among moving axes; <= comparisons give X > Y > Z on ties.
  assign w_sel_x = w_act_x && (!w_act_y || (r_tmax_x <= r_tmax_y))
                           && (!w_act_z || (r_tmax_x <= r_tmax_z));
  assign w_sel_y = !w_sel_x && w_act_y && (!w_act_z || (r_tmax_y <= r_tmax_z));
  assign w_sel_z = !w_sel_x && !w_sel_y && w_act_z;

  assign w_exit = !(w_act_x || w_act_y || w_act_z)
               || (w_sel_x && (r_dir_x[1] ? (r_x == '0) : (r_x == '1)))
               || (w_sel_y && (r_dir_y[1] ? (r_y == '0) : (r_y == '1)))
               || (w_sel_z && (r_dir_z[1] ? (r_z == '0) : (r_z == '1)));

  assign w_budget_done = (r_cnt == (r_eff_max - STEP_BITS'(1)));

  assign start_ready = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN);
  assign out_valid   = (r_state == S_RUN);
  assign out_last    = (r_state == S_RUN) && (w_budget_done || w_exit);
  assign out_x       = r_x;
  assign out_y       = r_y;
  assign out_z       = r_z;
`ifdef DDA_STEP_CNT_EN
  assign out_step    = r_cnt;
`endif

  assign w_accept = start_valid && start_ready;
  assign w_beat   = out_valid && out_ready;

  function automatic logic [T_BITS-1:0] sat_add(input logic [T_BITS-1:0] a,
                                                input logic [T_BITS-1:0] b);
    logic [T_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[T_BITS] ? {T_BITS{1'b1}} : s[T_BITS-1:0];
  endfunction

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (w_beat && out_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_dir_x    <= '0;
      r_dir_y    <= '0;
      r_dir_z    <= '0;
      r_tmax_x   <= '0;
      r_tmax_y   <= '0;
      r_tmax_z   <= '0;
      r_tdelta_x <= '0;
      r_tdelta_y <= '0;
      r_tdelta_z <= '0;
      r_eff_max  <= '0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_x        <= start_x;
      r_y        <= start_y;
      r_z        <= start_z;
      r_dir_x    <= dir_x;
      r_dir_y    <= dir_y;
      r_dir_z    <= dir_z;
      r_tmax_x   <= tmax_x;
      r_tmax_y   <= tmax_y;
      r_tmax_z   <= tmax_z;
      r_tdelta_x <= tdelta_x;
      r_tdelta_y <= tdelta_y;
      r_tdelta_z <= tdelta_z;
      r_eff_max  <= (max_steps == '0) ? STEP_BITS'(1) : max_steps;
      r_cnt      <= '0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + STEP_BITS'(1);
      // The final beat never steps, so coordinates cannot leave the grid.
      if (!out_last) begin
        if (w_sel_x) begin
          r_x      <= r_dir_x[1] ? r_x - 1'b1 : r_x + 1'b1;
          r_tmax_x <= sat_add(r_tmax_x, r_tdelta_x);
        end
        if (w_sel_y) begin
          r_y      <= r_dir_y[1] ? r_y - 1'b1 : r_y + 1'b1;
          r_tmax_y <= sat_add(r_tmax_y, r_tdelta_y);
        end
        if (w_sel_z) begin
          r_z      <= r_dir_z[1] ? r_z - 1'b1 : r_z + 1'b1;
          r_tmax_z <= sat_add(r_tmax_z, r_tdelta_z);
        end
      end
    end
  end

endmodule

// File: tb/tb_voxel_dda_stepper.sv
// Self-checking bench for voxel_dda_stepper: directed test-plan rays plus random rays
// checked against a behavioural DDA walk model.
module tb_voxel_dda_stepper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [4:0]  start_x, start_y, start_z;
  logic [1:0]  dir_x, dir_y, dir_z;
  logic [15:0] tmax_x, tmax_y, tmax_z;
  logic [15:0] tdelta_x, tdelta_y, tdelta_z;
  logic [7:0]  max_steps;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_x, out_y, out_z;
  logic        out_last;
  logic        busy;
`ifdef DDA_STEP_CNT_EN
  logic [7:0]  out_step;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int z;
    bit last;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  voxel_dda_stepper dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_x(start_x), .start_y(start_y), .start_z(start_z),
    .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
    .tmax_x(tmax_x), .tmax_y(tmax_y), .tmax_z(tmax_z),
    .tdelta_x(tdelta_x), .tdelta_y(tdelta_y), .tdelta_z(tdelta_z),
    .max_steps(max_steps),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_last(out_last),
`ifdef DDA_STEP_CNT_EN
    .busy(busy),
    .out_step(out_step)
`else
    .busy(busy)
`endif
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int dir_val(input logic [1:0] d);
    if (d == 2'b01) return 1;
    if (d == 2'b11) return -1;
    return 0;
  endfunction

  // Walk the ray with plain integer arithmetic, collecting every voxel visited.
  function automatic void build_model(input int sx, sy, sz, input logic [1:0] dx, dy, dz,
                                      input int t0x, t0y, t0z, input int ddx, ddy, ddz,
                                      input int ms);
    int pos[3];
    int d[3];
    int t[3];
    int dl[3];
    int eff;
    int sel;
    bit ext;
    beat_t b;
    pos = '{sx, sy, sz};
    d   = '{dir_val(dx), dir_val(dy), dir_val(dz)};
    t   = '{t0x, t0y, t0z};
    dl  = '{ddx, ddy, ddz};
    eff = (ms == 0) ? 1 : ms;
    exp_q.delete();
    for (int n = 0; n < 300; n++) begin
      sel = -1;
      for (int a = 0; a < 3; a++)
        if (d[a] != 0 && (sel < 0 || t[a] < t[sel])) sel = a;
      ext = (sel < 0) || (pos[sel] + d[sel] < 0) || (pos[sel] + d[sel] > 31);
      b.x = pos[0]; b.y = pos[1]; b.z = pos[2];
      b.last = (n == eff - 1) || ext;
      exp_q.push_back(b);
      if (b.last) break;
      pos[sel] += d[sel];
      t[sel] = (t[sel] + dl[sel] > 65535) ? 65535 : t[sel] + dl[sel];
    end
  endfunction

  // mode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random.
  // abort_at >= 0 pulses rst while that beat index is presented.
  task automatic run_ray(input string tag,
                         input logic [4:0] sx, sy, sz, input logic [1:0] dx, dy, dz,
                         input logic [15:0] t0x, t0y, t0z, input logic [15:0] ddx, ddy, ddz,
                         input logic [7:0] ms, input int mode, input int abort_at);
    int idx = 0;
    int cyc = 0;
    bit done = 0;
    bit stalled = 0;
    logic [4:0] px, py, pz;
    logic pl;
    build_model(sx, sy, sz, dx, dy, dz, t0x, t0y, t0z, ddx, ddy, ddz, ms);
    @(posedge clk); #1;
    start_x = sx; start_y = sy; start_z = sz;
    dir_x = dx; dir_y = dy; dir_z = dz;
    tmax_x = t0x; tmax_y = t0y; tmax_z = t0z;
    tdelta_x = ddx; tdelta_y = ddy; tdelta_z = ddz;
    max_steps = ms;
    start_valid = 1'b1;
    chk({tag, " start_ready idle"}, int'(start_ready), 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk({tag, " first valid latency"}, int'(out_valid), 1);
    while (!done && cyc < 1000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        chk({tag, " stall x"}, int'(out_x), int'(px));
        chk({tag, " stall y"}, int'(out_y), int'(py));
        chk({tag, " stall z"}, int'(out_z), int'(pz));
        chk({tag, " stall last"}, int'(out_last), int'(pl));
      end
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, " abort out_valid"}, int'(out_valid), 0);
        chk({tag, " abort busy"}, int'(busy), 0);
        chk({tag, " abort start_ready"}, int'(start_ready), 1);
        chk({tag, " abort out_last"}, int'(out_last), 0);
        return;
      end
      chk({tag, " out_valid"}, int'(out_valid), 1);
      chk({tag, " busy"}, int'(busy), 1);
      stalled = 1'b0;
      if (out_ready && idx < exp_q.size()) begin
        chk($sformatf("%s beat%0d x", tag, idx), int'(out_x), exp_q[idx].x);
        chk($sformatf("%s beat%0d y", tag, idx), int'(out_y), exp_q[idx].y);
        chk($sformatf("%s beat%0d z", tag, idx), int'(out_z), exp_q[idx].z);
        chk($sformatf("%s beat%0d last", tag, idx), int'(out_last), int'(exp_q[idx].last));
`ifdef DDA_STEP_CNT_EN
        chk($sformatf("%s beat%0d step", tag, idx), int'(out_step), idx);
`endif
        if (out_last) done = 1'b1;
        idx++;
      end else if (!out_ready) begin
        stalled = 1'b1;
        px = out_x; py = out_y; pz = out_z; pl = out_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL %s timeout: observed beats %0d expected %0d", tag, idx, exp_q.size());
    end
    chk({tag, " beat count"}, idx, exp_q.size());
    chk({tag, " post start_ready"}, int'(start_ready), 1);
    chk({tag, " post out_valid"}, int'(out_valid), 0);
    chk({tag, " post busy"}, int'(busy), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    out_ready = 1'b0;
    {start_x, start_y, start_z} = '0;
    {dir_x, dir_y, dir_z} = '0;
    {tmax_x, tmax_y, tmax_z} = '0;
    {tdelta_x, tdelta_y, tdelta_z} = '0;
    max_steps = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset start_ready", int'(start_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_last", int'(out_last), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset out_x", int'(out_x), 0);
    chk("reset out_y", int'(out_y), 0);
    chk("reset out_z", int'(out_z), 0);
    rst = 1'b0;

    run_ray("xsweep", 5'd0, 5'd0, 5'd0, 2'b01, 2'b00, 2'b00,
            16'd0, 16'd0, 16'd0, 16'd10, 16'd0, 16'd0, 8'd40, 0, -1);
    run_ray("tiebreak", 5'd3, 5'd3, 5'd3, 2'b01, 2'b01, 2'b01,
            16'd5, 16'd5, 16'd5, 16'd8, 16'd8, 16'd8, 8'd4, 0, -1);
    run_ray("negexit", 5'd0, 5'd5, 5'd5, 2'b11, 2'b00, 2'b00,
            16'd0, 16'd0, 16'd0, 16'd10, 16'd0, 16'd0, 8'd10, 0, -1);
    run_ray("saturate", 5'd0, 5'd0, 5'd0, 2'b01, 2'b01, 2'b00,
            16'hFFF0, 16'hFFFF, 16'd0, 16'h0100, 16'h0010, 16'd0, 8'd3, 0, -1);
    run_ray("backpress", 5'd3, 5'd3, 5'd3, 2'b01, 2'b01, 2'b01,
            16'd5, 16'd5, 16'd5, 16'd8, 16'd8, 16'd8, 8'd4, 1, -1);
    run_ray("nodir", 5'd7, 5'd8, 5'd9, 2'b00, 2'b10, 2'b00,
            16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 8'd20, 0, -1);
    run_ray("maxzero", 5'd10, 5'd10, 5'd10, 2'b01, 2'b11, 2'b01,
            16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4, 8'd0, 0, -1);
    run_ray("abort", 5'd0, 5'd0, 5'd0, 2'b01, 2'b00, 2'b00,
            16'd0, 16'd0, 16'd0, 16'd10, 16'd0, 16'd0, 8'd40, 0, 2);
    run_ray("after_abort", 5'd3, 5'd3, 5'd3, 2'b01, 2'b01, 2'b01,
            16'd5, 16'd5, 16'd5, 16'd8, 16'd8, 16'd8, 8'd4, 0, -1);

    for (int r = 0; r < 25; r++) begin
      run_ray($sformatf("rand%0d", r),
              5'($urandom), 5'($urandom), 5'($urandom),
              2'($urandom), 2'($urandom), 2'($urandom),
              16'($urandom_range(0, 300)), 16'($urandom_range(0, 300)), 16'($urandom_range(0, 300)),
              16'($urandom_range(1, 200)), 16'($urandom_range(1, 200)), 16'($urandom_range(1, 200)),
              8'($urandom_range(0, 70)), 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
